rgb_stream_writer: RTL and testbench
====================================

// Module: rgb_stream_writer
//
// PURPOSE
// - Upstream feeder of the slice framebuffer RAM.
// - Takes the parallel 24-bit RGB video stream from the SoM, sampled in the FPGA clock domain.
// - Converts each pixel to RGB565 and generates a linear write address plus write strobe for the RAM.
// - Manages a double-buffered frame: bank swap happens only on a complete, error-free frame.
//
// PARAMETERS
// - IMG_W   80  active pixels per line
// - IMG_H   48  active lines per frame
// - ADDR_W  32  write address width; must hold 2*IMG_W*IMG_H
//
// PORTS
// - clk          in   1       system clock
// - nrst         in   1       asynchronous active-low reset
// - rgb_data     in   24      {R[7:0],G[7:0],B[7:0]}; valid when rgb_de=1
// - rgb_de       in   1       data enable; high during active pixels of a line
// - rgb_vsync    in   1       frame sync, active high; rising edge = frame start
// - write_addr   out  ADDR_W  RAM write address
// - write_data   out  16      RGB565 pixel
// - write_enab   out  1       RAM write strobe, one cycle per pixel
// - read_bank    out  1       bank the downstream reader shall use (= ~write bank)
// - frame_done   out  1       1-cycle pulse: bank swapped, new frame readable
// - frame_err    out  1       1-cycle pulse: frame discarded (bad geometry)
// - err_count    out  16      discarded-frame counter; present only with RGB_STREAM_ERRCNT_EN
//
// BEHAVIOUR
// - Reset values:
//   - all outputs 0; read_bank=0, write bank=1
//   - x=0, y=0, state=SYNC_WAIT
//   - rgb_de/rgb_vsync edge-history flops cleared
// - Outputs are registered. A pixel sampled at edge N appears on write_* after edge N+1, so latency is 1 cycle.
// - Pixel format: write_data = {R[7:3],G[7:2],B[7:3]}.
// - Address: write_addr = bank*IMG_W*IMG_H + y*IMG_W + x, zero-extended to ADDR_W.
// - FSM states:
//   - SYNC_WAIT: ignore rgb_de. On vsync rising edge -> ACTIVE, with x=0, y=0, frame_bad=0.
//   - ACTIVE:
//     - rgb_de=1 and x<IMG_W: write pixel, x++.
//     - rgb_de=1 and x==IMG_W: pixel dropped, frame_bad=1.
//     - rgb_de falling edge: if x!=IMG_W then frame_bad=1; then y++, x=0.
//     - When y reaches IMG_H -> SKIP.
//   - SKIP:
//     - rgb_de=1: frame_bad=1, no write.
//     - vsync rising edge -> frame close (below), then ACTIVE.
// - Frame close (on vsync rising edge in ACTIVE or SKIP):
//   - Good frame (y==IMG_H and frame_bad=0): toggle write bank and read_bank, pulse frame_done.
//   - Otherwise: keep banks, pulse frame_err.
//   - In both cases: x=0, y=0, frame_bad=0.
// - Simultaneous events:
//   - vsync rising edge and rgb_de=1 in the same cycle: vsync wins, the pixel is dropped and not flagged.
//   - rgb_de falling edge coinciding with a vsync edge: line ends, then the frame close is evaluated with the incremented y.
// - The first vsync after reset only starts a frame; it never pulses frame_done or frame_err.
// - Reset mid-frame: everything returns to reset values; that frame is never swapped.
// - frame_done and frame_err are mutually exclusive; neither is high for more than one cycle.
//
// CONFIGURATION
// - RGB_STREAM_ERRCNT_EN defined:
//   - err_count port exists, reset to 0.
//   - Increments on each frame_err pulse; saturates at 16'hFFFF.
// - RGB_STREAM_ERRCNT_EN undefined:
//   - err_count port and counter are absent.
//   - All other behaviour is identical.
//
// TESTING
// - Reset, vsync, 48 lines of 80 pixels (pixel 0 = 24'hFF8040), vsync -> 3840 writes:
//   - addresses 3840..7679
//   - first write_data = 16'hFC08
//   - frame_done 1 cycle, read_bank=1
// - Second good frame -> addresses 0..3839, frame_done, read_bank=0.
// - Line 5 carries 79 pixels -> frame_err pulse, no frame_done, read_bank unchanged; with RGB_STREAM_ERRCNT_EN, err_count=1.
// - Line carries 81 pixels -> 81st pixel not written; frame_err at next vsync.
// - 49 lines -> no write for line 49, frame_err at vsync.
// - nrst asserted at line 20, then released with a full frame sent -> that frame only starts (no pulse); the next full frame gives frame_done.
// - vsync rising edge coincident with rgb_de=1 -> no write that cycle; x=0, y=0 afterwards.

Source files
------------

// File: rtl/rgb_stream_writer_if.sv
// Video-in / RAM-write signal bundle for rgb_stream_writer.
// master = the writer block, slave = the video source plus RAM side.
interface rgb_stream_writer_if #(
  parameter int ADDR_W = 32
);
  logic [23:0]       rgb_data;
  logic              rgb_de;
  logic              rgb_vsync;
  logic [ADDR_W-1:0] write_addr;
  logic [15:0]       write_data;
  logic              write_enab;

  modport master (
    input  rgb_data, rgb_de, rgb_vsync,
    output write_addr, write_data, write_enab
  );

  modport slave (
    output rgb_data, rgb_de, rgb_vsync,
    input  write_addr, write_data, write_enab
  );
endinterface

// File: rtl/rgb_stream_writer.sv
// RGB888 stream to RGB565 double-buffered framebuffer writer; banks swap only on clean frames.
// Optional discarded-frame counter on err_count when RGB_STREAM_ERRCNT_EN is defined.
module rgb_stream_writer #(
  parameter int IMG_W  = 80,
  parameter int IMG_H  = 48,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                nrst,
  rgb_stream_writer_if.master bus,
  output logic                read_bank,
  output logic                frame_done,
  output logic                frame_err
`ifdef RGB_STREAM_ERRCNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  localparam int X_W       = $clog2(IMG_W + 1);
  localparam int Y_W       = $clog2(IMG_H + 1);
  localparam int FRAME_PIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    SYNC_WAIT,
    ACTIVE,
    SKIP
  } state_t;

  // Input stage plus one history flop per strobe for edge detection.
  logic [23:0] r_rgb_data;
  logic        r_de;
  logic        r_vs;
  logic        r_de_d;
  logic        r_vs_d;

  // NOTE: registers are always assigned with <= so every flop samples pre-edge values in parallel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rgb_data <= '0;
      r_de       <= 1'b0;
      r_vs       <= 1'b0;
      r_de_d     <= 1'b0;
      r_vs_d     <= 1'b0;
    end else begin
      r_rgb_data <= bus.rgb_data;
      r_de       <= bus.rgb_de;
      r_vs       <= bus.rgb_vsync;
      r_de_d     <= r_de;
      r_vs_d     <= r_vs;
    end
  end

  state_t         r_state;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_frame_bad;
  logic           r_wbank;

  logic              w_vs_rise;
  logic              w_de_fall;
  logic              w_line_end;
  logic [Y_W-1:0]    w_y_inc;
  logic [Y_W-1:0]    w_close_y;
  logic              w_close_bad;
  logic              w_close_good;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [15:0]       w_rgb565;

  assign w_vs_rise  = r_vs & ~r_vs_d;
  assign w_de_fall  = r_de_d & ~r_de;
  assign w_line_end = w_de_fall && (r_state == ACTIVE);
  assign w_y_inc    = r_y + Y_W'(1);

  // A line ending in the same cycle as vsync is counted before the frame is judged.
  assign w_close_y    = w_line_end ? w_y_inc : r_y;
  assign w_close_bad  = r_frame_bad | (w_line_end & (r_x != X_W'(IMG_W)));
  assign w_close_good = (w_close_y == Y_W'(IMG_H)) & ~w_close_bad;

  assign w_pix_addr = (r_wbank ? ADDR_W'(FRAME_PIX) : '0)
                    + ADDR_W'(r_y) * ADDR_W'(IMG_W)
                    + ADDR_W'(r_x);
  assign w_rgb565   = {r_rgb_data[23:19], r_rgb_data[15:10], r_rgb_data[7:3]};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= SYNC_WAIT;
      r_x            <= '0;
      r_y            <= '0;
      r_frame_bad    <= 1'b0;
      r_wbank        <= 1'b1;
      read_bank      <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      bus.write_enab <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
    end else begin
      bus.write_enab <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;

      unique case (r_state)
        SYNC_WAIT: begin
          if (w_vs_rise) begin
            r_state     <= ACTIVE;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_bad <= 1'b0;
          end
        end

        ACTIVE, SKIP: begin
          if (w_vs_rise) begin
            // vsync outranks a coincident pixel: it is dropped without marking the frame.
            if (w_close_good) begin
              r_wbank    <= ~r_wbank;
              read_bank  <= r_wbank;
              frame_done <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            r_state     <= ACTIVE;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_bad <= 1'b0;
          end else if (r_state == SKIP) begin
            if (r_de) r_frame_bad <= 1'b1;
          end else if (r_de) begin
            if (r_x < X_W'(IMG_W)) begin
              bus.write_enab <= 1'b1;
              bus.write_addr <= w_pix_addr;
              bus.write_data <= w_rgb565;
              r_x            <= r_x + X_W'(1);
            end else begin
              r_frame_bad    <= 1'b1;
            end
          end else if (w_line_end) begin
            r_x         <= '0;
            r_y         <= w_y_inc;
            r_frame_bad <= w_close_bad;
            if (w_y_inc == Y_W'(IMG_H)) r_state <= SKIP;
          end
        end

        default: r_state <= SYNC_WAIT;
      endcase
    end
  end

`ifdef RGB_STREAM_ERRCNT_EN
  logic w_close_err;

  assign w_close_err = (r_state != SYNC_WAIT) && w_vs_rise && !w_close_good;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_count <= '0;
    end else if (w_close_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_stream_writer.sv
// Self-checking bench for rgb_stream_writer: cycle-exact scoreboard fed by a frame-level model.
module tb_rgb_stream_writer;

  localparam int IMG_W     = 80;
  localparam int IMG_H     = 48;
  localparam int ADDR_W    = 32;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int N_TBL     = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic read_bank;
  logic frame_done;
  logic frame_err;
`ifdef RGB_STREAM_ERRCNT_EN
  logic [15:0] err_count;
`endif

  rgb_stream_writer_if #(.ADDR_W(ADDR_W)) bus ();

  rgb_stream_writer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .read_bank (read_bank),
    .frame_done(frame_done),
    .frame_err (frame_err)
`ifdef RGB_STREAM_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic        good;
    logic        rb;
    logic [15:0] errs;
  } ev_t;

  typedef struct {
    logic [23:0] rgb;
    logic [15:0] rgb565;
  } pix_vec_t;

  wr_t      wq[$];
  ev_t      eq[$];
  pix_vec_t tbl[N_TBL];

  int n_vec  = 0;
  int n_fail = 0;

  // Frame-level reference state
  bit m_started;
  bit m_wbank;
  bit m_rb;
  bit m_bad;
  int m_lines;
  int m_len;
  int m_errs;
  bit prev_de;
  bit prev_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  task automatic m_pixel(input logic [15:0] exp_d);
    logic [ADDR_W-1:0] a;
    if (m_started) begin
      if (m_lines < IMG_H && m_len < IMG_W) begin
        a = ADDR_W'((m_wbank ? FRAME_PIX : 0) + m_lines * IMG_W + m_len);
        wq.push_back('{cyc: cyc + 2, addr: a, data: exp_d});
      end
      m_len++;
    end
  endtask

  task automatic m_line_end();
    if (m_started) begin
      if (m_len != IMG_W) m_bad = 1'b1;
      m_lines++;
    end
    m_len = 0;
  endtask

  task automatic m_frame_sync();
    bit good;
    if (m_started) begin
      good = (m_lines == IMG_H) && !m_bad;
      if (good) begin
        m_wbank = !m_wbank;
        m_rb    = !m_rb;
      end else if (m_errs < 65535) begin
        m_errs++;
      end
      eq.push_back('{cyc: cyc + 2, good: good, rb: m_rb, errs: 16'(m_errs)});
    end
    m_started = 1'b1;
    m_lines   = 0;
    m_len     = 0;
    m_bad     = 1'b0;
  endtask

  // One input cycle: drive after the falling edge, then let the model react to the same values.
  task automatic tick(input bit de, input bit vs, input logic [23:0] d, input logic [15:0] exp_d);
    @(negedge clk);
    bus.rgb_de    = de;
    bus.rgb_vsync = vs;
    bus.rgb_data  = d;
    if (prev_de && !de) m_line_end();
    if (vs && !prev_vs) m_frame_sync();
    else if (de)        m_pixel(exp_d);
    prev_de = de;
    prev_vs = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 24'h0, 16'h0);
  endtask

  task automatic vsync();
    tick(1'b0, 1'b1, 24'h0, 16'h0);
    tick(1'b0, 1'b1, 24'h0, 16'h0);
    idle(2);
  endtask

  task automatic send_line(input int len, input int blank, input bit use_tbl);
    for (int p = 0; p < len; p++) begin
      logic [23:0] d;
      logic [15:0] e;
      d = 24'($urandom);
      e = to565(d);
      if (use_tbl && p < N_TBL) begin
        d = tbl[p].rgb;
        e = tbl[p].rgb565;
      end
      tick(1'b1, 1'b0, d, e);
    end
    idle(blank);
  endtask

  // Lines then the closing vsync; optionally the last line's de fall lands on the vsync rise.
  task automatic send_frame(input int n_lines, input int bad_line, input int bad_len,
                            input bit coincide, input bit tbl_first);
    for (int l = 0; l < n_lines; l++) begin
      send_line((l == bad_line) ? bad_len : IMG_W,
                (coincide && l == n_lines - 1) ? 0 : 2,
                tbl_first && l == 0);
    end
    vsync();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst          = 1'b0;
    bus.rgb_de    = 1'b0;
    bus.rgb_vsync = 1'b0;
    bus.rgb_data  = '0;
    check("queue_empty_at_reset", 32'(wq.size() + eq.size()), 32'd0);
    wq.delete();
    eq.delete();
    prev_de   = 1'b0;
    prev_vs   = 1'b0;
    m_started = 1'b0;
    m_wbank   = 1'b1;
    m_rb      = 1'b0;
    m_bad     = 1'b0;
    m_lines   = 0;
    m_len     = 0;
    m_errs    = 0;
    repeat (3) @(negedge clk);
    check("rst_write_enab", 32'(bus.write_enab), 32'd0);
    check("rst_write_addr", bus.write_addr, 32'd0);
    check("rst_write_data", 32'(bus.write_data), 32'd0);
    check("rst_read_bank", 32'(read_bank), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
`ifdef RGB_STREAM_ERRCNT_EN
    check("rst_err_count", 32'(err_count), 32'd0);
`endif
    nrst = 1'b1;
  endtask

  task automatic monitor();
    forever begin
      bit  exp_we;
      bit  exp_ev;
      wr_t w;
      ev_t e;
      @(negedge clk);
      exp_we = (wq.size() != 0) && (wq[0].cyc == cyc);
      if (exp_we || bus.write_enab) begin
        check("write_enab", 32'(bus.write_enab), 32'(exp_we));
        if (exp_we) begin
          w = wq.pop_front();
          if (bus.write_enab) begin
            check("write_addr", bus.write_addr, w.addr);
            check("write_data", 32'(bus.write_data), 32'(w.data));
          end
        end
      end
      exp_ev = (eq.size() != 0) && (eq[0].cyc == cyc);
      if (exp_ev || frame_done || frame_err) begin
        e = exp_ev ? eq[0] : '{cyc: 0, good: 1'b0, rb: 1'b0, errs: 16'h0};
        check("frame_done", 32'(frame_done), 32'(exp_ev && e.good));
        check("frame_err", 32'(frame_err), 32'(exp_ev && !e.good));
        if (exp_ev) begin
          void'(eq.pop_front());
          check("read_bank", 32'(read_bank), 32'(e.rb));
`ifdef RGB_STREAM_ERRCNT_EN
          check("err_count", 32'(err_count), 32'(e.errs));
`endif
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{rgb: 24'hFF8040, rgb565: 16'hFC08};
    tbl[1] = '{rgb: 24'h000000, rgb565: 16'h0000};
    tbl[2] = '{rgb: 24'hFFFFFF, rgb565: 16'hFFFF};
    tbl[3] = '{rgb: 24'h070307, rgb565: 16'h0000};
    tbl[4] = '{rgb: 24'h080408, rgb565: 16'h0821};
    tbl[5] = '{rgb: 24'hF80000, rgb565: 16'hF800};
    tbl[6] = '{rgb: 24'h00FC00, rgb565: 16'h07E0};
    tbl[7] = '{rgb: 24'h0000F8, rgb565: 16'h001F};

    bus.rgb_de    = 1'b0;
    bus.rgb_vsync = 1'b0;
    bus.rgb_data  = '0;

    fork
      monitor();
    join_none

    do_reset();

    // First vsync only opens a frame; first frame goes to bank 1 and starts with the table pixels.
    vsync();
    send_frame(IMG_H, -1, 0, 1'b0, 1'b1);
    send_frame(IMG_H, -1, 0, 1'b0, 1'b0);
    // Short line, long line, extra line: each discards its frame.
    send_frame(IMG_H, 5, IMG_W - 1, 1'b0, 1'b0);
    send_frame(IMG_H, 10, IMG_W + 1, 1'b0, 1'b0);
    send_frame(IMG_H + 1, -1, 0, 1'b0, 1'b0);
    // Last line's de fall on the same cycle as the closing vsync rise: still a good frame.
    send_frame(IMG_H, -1, 0, 1'b1, 1'b0);

    // Reset in the middle of a frame, then a full frame that only starts and one that completes.
    for (int l = 0; l < 20; l++) send_line(IMG_W, 2, 1'b0);
    idle(4);
    do_reset();
    vsync();
    send_frame(IMG_H, -1, 0, 1'b0, 1'b0);

    // vsync rising on an active pixel: pixel dropped, new frame begins at x=0, y=0.
    for (int l = 0; l < 3; l++) send_line(IMG_W, 2, 1'b0);
    send_line(10, 0, 1'b0);
    begin
      logic [23:0] d;
      d = 24'($urandom);
      tick(1'b1, 1'b1, d, to565(d));
      d = 24'($urandom);
      tick(1'b1, 1'b1, d, to565(d));
    end
    send_line(IMG_W - 1, 2, 1'b0);
    send_frame(IMG_H - 1, -1, 0, 1'b0, 1'b0);

    // Random geometry and blanking
    for (int f = 0; f < 2; f++) begin
      int n_lines;
      n_lines = IMG_H - 1 + int'($urandom_range(0, 3));
      if (n_lines > IMG_H + 1) n_lines = IMG_H;
      for (int l = 0; l < n_lines; l++) begin
        int len;
        len = ($urandom_range(0, 9) == 0) ? IMG_W - 2 + int'($urandom_range(0, 4)) : IMG_W;
        send_line(len, int'($urandom_range(1, 3)), 1'b0);
      end
      vsync();
    end

    idle(4);
    check("write_queue_drained", 32'(wq.size()), 32'd0);
    check("event_queue_drained", 32'(eq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
